// File: rtl/fu_mul_sched.sv
// Round-robin scheduler sharing one non-pipelined multi-cycle multiplier FU among N requesters.
// Define FU_MUL_SCHED_TIMEOUT_EN to add a WAIT watchdog and the sticky err output.
module fu_mul_sched #(
    parameter int N       = 4,
    parameter int TAG_W   = 4,
    parameter int LAT     = 7,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*32-1:0]        req_a,
    input  logic [N*32-1:0]        req_b,
    input  logic [N*TAG_W-1:0]     req_tag,
    output logic                   fu_en,
    output logic [31:0]            fu_a,
    output logic [31:0]            fu_b,
    input  logic                   fu_finish,
    input  logic [31:0]            fu_res,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic [$clog2(N)-1:0]   res_src,
`ifdef FU_MUL_SCHED_TIMEOUT_EN
    output logic                   err,
`endif
    output logic                   busy
);

    localparam int SRC_W = $clog2(N);
    localparam int CD_W  = $clog2(LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    if (N < 2 || N > 8 || LAT < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("fu_mul_sched: unsupported parameter value");
    end

    logic [1:0]       state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]      fu_a_q, fu_a_d;
    logic [31:0]      fu_b_q, fu_b_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [SRC_W-1:0] res_src_q, res_src_d;
    logic             res_valid_q, res_valid_d;

`ifdef FU_MUL_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
`endif

    logic [31:0]      a_arr   [N];
    logic [31:0]      b_arr   [N];
    logic [TAG_W-1:0] tag_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign a_arr[i]   = req_a[32*i +: 32];
        assign b_arr[i]   = req_b[32*i +: 32];
        assign tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
    end

    // Search starts one past the last granted index so every requester gets a turn.
    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic             can_grant;

    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(rr_ptr_q) + k) % N;
            if (!gnt_found && req_valid[SRC_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(cand);
            end
        end
    end

    assign can_grant = (state_q == S_IDLE) && (cd_q == '0) && gnt_found;
    assign req_ready = can_grant ? (N'(1) << gnt_idx) : '0;

    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        rr_ptr_d    = rr_ptr_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_src_d   = res_src_q;
        res_valid_d = res_valid_q;
`ifdef FU_MUL_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    fu_a_d    = a_arr[gnt_idx];
                    fu_b_d    = b_arr[gnt_idx];
                    res_tag_d = tag_arr[gnt_idx];
                    res_src_d = gnt_idx;
                    rr_ptr_d  = gnt_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef FU_MUL_SCHED_TIMEOUT_EN
                wd_d    = WD_W'(TIMEOUT - 1);
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fu_finish) begin
                    res_data_d  = fu_res;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
`ifdef FU_MUL_SCHED_TIMEOUT_EN
                // FU presumed hung: hand back a marker and re-arm the cooldown in case it wakes up later.
                else if (wd_q == '0) begin
                    res_data_d  = 32'hDEAD_BEEF;
                    res_valid_d = 1'b1;
                    err_d       = 1'b1;
                    cd_d        = CD_W'(LAT);
                    state_d     = S_HOLD;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cd_q        <= CD_W'(LAT);
            rr_ptr_q    <= SRC_W'(N - 1);
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_src_q   <= '0;
            res_valid_q <= 1'b0;
`ifdef FU_MUL_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            rr_ptr_q    <= rr_ptr_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_src_q   <= res_src_d;
            res_valid_q <= res_valid_d;
`ifdef FU_MUL_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign fu_en     = (state_q == S_ISSUE);
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_src   = res_src_q;
    assign busy      = (state_q != S_IDLE) || (cd_q != '0);
`ifdef FU_MUL_SCHED_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_fu_mul_sched.sv
// Scoreboard bench for fu_mul_sched: requester/FU models drive the DUT, a negedge monitor
// predicts grants, FU issue and results from the scheduling rules and compares every cycle.
module tb_fu_mul_sched;

    localparam int N     = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
    logic [N*TAG_W-1:0] req_tag;
    logic             fu_en;
    logic [31:0]      fu_a, fu_b;
    logic             fu_finish;
    logic [31:0]      fu_res;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [1:0]       res_src;
    logic             busy;
`ifdef FU_MUL_SCHED_TIMEOUT_EN
    logic             err;
`endif

    logic [31:0]      a_v   [N];
    logic [31:0]      b_v   [N];
    logic [TAG_W-1:0] tag_v [N];

    always_comb begin
        req_a   = '0;
        req_b   = '0;
        req_tag = '0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32]       = a_v[i];
            req_b[32*i +: 32]       = b_v[i];
            req_tag[TAG_W*i +: TAG_W] = tag_v[i];
        end
    end

    fu_mul_sched #(.N(N), .TAG_W(TAG_W), .LAT(LAT), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .fu_en     (fu_en),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_finish (fu_finish),
        .fu_res    (fu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_src   (res_src),
`ifdef FU_MUL_SCHED_TIMEOUT_EN
        .err       (err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multi-cycle FU: not reset, so an op in flight across a DUT reset still finishes.
    int          fu_cnt  = 0;
    logic [31:0] fu_prod = '0;
    logic [31:0] fu_junk = '0;
    logic        fu_force = 1'b0;

    always @(posedge clk) begin
        fu_junk <= $urandom;
        if (fu_en) begin
            fu_cnt  <= LAT;
            fu_prod <= fu_a * fu_b;
        end else if (fu_cnt != 0) begin
            fu_cnt <= fu_cnt - 1;
        end
    end
    assign fu_finish = (fu_cnt == 1) || fu_force;
    assign fu_res    = fu_finish ? fu_prod : fu_junk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        logic [1:0]       s;
    } res_t;

    res_t        exp_q[$];
    res_t        held;
    int          gnt_log[$];
    int          gnt_cyc[$];
    int          cyc_since;
    bit          outstanding, issue_due, in_flight, fin_pend, holding, fin_now;
    int          last_g, gi;
    logic [31:0] iss_a, iss_b;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;

    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0; issue_due = 0; in_flight = 0; fin_pend = 0; holding = 0;
            last_g = N - 1; cyc_since = 0; hs = '0;
            exp_q.delete(); gnt_log.delete(); gnt_cyc.delete();
            chk("rst_fu_ab", 64'({fu_a, fu_b}), 64'(0));
            chk("rst_res_data", 64'(res_data), 64'(0));
            chk("rst_ctl", 64'({req_ready, fu_en, res_valid, res_tag, res_src}), 64'(0));
            chk("rst_busy", 64'(busy), 64'(1));
`ifdef FU_MUL_SCHED_TIMEOUT_EN
            chk("rst_err", 64'(err), 64'(0));
`endif
        end else begin
            chk("busy", 64'(busy), 64'(outstanding || cyc_since < LAT));
            chk("res_valid", 64'(res_valid), 64'(holding || fin_pend));
            if (fin_pend) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 64'(1), 64'(0));
                end else begin
                    held = exp_q.pop_front();
                    chk("res_data", 64'(res_data), 64'(held.d));
                    chk("res_tag", 64'(res_tag), 64'(held.t));
                    chk("res_src", 64'(res_src), 64'(held.s));
                end
                holding  = 1;
                fin_pend = 0;
            end else if (holding) begin
                chk("res_stable", 64'({res_data, res_tag, res_src}), 64'({held.d, held.t, held.s}));
            end

            chk("fu_en", 64'(fu_en), 64'(issue_due));
            if (issue_due) begin
                chk("fu_a", 64'(fu_a), 64'(iss_a));
                chk("fu_b", 64'(fu_b), 64'(iss_b));
            end
            fin_now = in_flight && fu_finish;
            if (fin_now) begin
                in_flight = 0;
                fin_pend  = 1;
            end
            if (issue_due) in_flight = 1;
            issue_due = 0;

            // Next requester after the last granted one, once idle and cooled down.
            exp_rdy = '0;
            gi = -1;
            if (!outstanding && cyc_since >= LAT) begin
                for (int k = 1; k <= N; k++) begin
                    if (gi < 0 && req_valid[(last_g + k) % N]) gi = (last_g + k) % N;
                end
            end
            if (gi >= 0) exp_rdy[gi] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (gi >= 0) begin
                exp_q.push_back({a_v[gi] * b_v[gi], tag_v[gi], 2'(gi)});
                iss_a = a_v[gi];
                iss_b = b_v[gi];
                outstanding = 1;
                issue_due   = 1;
                last_g      = gi;
                gnt_log.push_back(gi);
                gnt_cyc.push_back(cyc_since);
            end
            hs = req_valid & req_ready;

            if (holding && res_ready) begin
                holding     = 0;
                outstanding = 0;
            end
            cyc_since++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        a_v[i] = a; b_v[i] = b; tag_v[i] = t;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_hs(input int i);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!hs[i] && n < 200);
        chk("grant_timeout", 64'(hs[i]), 64'(1));
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("res_timeout", 64'(res_valid), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        res_ready = 1'b1;
        while ((outstanding || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain", 64'({outstanding, 31'(exp_q.size())}), 64'(0));
    endtask

    initial begin
        int exp_ord[5];
        int n;
        exp_ord = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0; b_v[i] = '0; tag_v[i] = '0;
        end

        // Single request straight after reset: held off by cooldown, granted at cycle LAT.
        tick();
        do_reset();
        tick();
        set_req(0, 32'd3, 32'd5, 4'd2);
        wait_hs(0);
        chk("first_grant_cycle", 64'(gnt_cyc.size() > 0 ? gnt_cyc[0] : -1), 64'(LAT));
        wait_res();
        chk("t1_data", 64'(res_data), 64'(15));
        chk("t1_tag_src", 64'({res_tag, res_src}), 64'({4'd2, 2'd0}));
        drain();

        // All requesters continuously valid: rotation from reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 4'($urandom));
        n = 0;
        while (gnt_log.size() < 5 && n < 300) begin
            tick();
            n++;
            for (int i = 0; i < N; i++)
                if (hs[i]) begin
                    a_v[i] = $urandom; b_v[i] = $urandom; tag_v[i] = 4'($urandom);
                end
        end
        for (int k = 0; k < 5; k++)
            chk("rr_order", 64'(gnt_log.size() > k ? gnt_log[k] : -1), 64'(exp_ord[k]));
        drain();

        // Back-pressure from the CDB while another requester waits.
        res_ready = 1'b0;
        set_req(1, 32'h1234_5678, 32'h10, 4'd7);
        wait_hs(1);
        wait_res();
        set_req(2, 32'd9, 32'd9, 4'd1);
        repeat (20) tick();
        chk("hold_no_grant", 64'(gnt_log[gnt_log.size() - 1]), 64'(1));
        res_ready = 1'b1;
        wait_hs(2);
        drain();

        // Truncated product.
        set_req(3, 32'hFFFF_FFFF, 32'd2, 4'd9);
        wait_hs(3);
        wait_res();
        chk("trunc_data", 64'(res_data), 64'(32'hFFFF_FFFE));
        drain();

        // Reset while the FU is running, then a stray finish during cooldown.
        set_req(0, 32'd11, 32'd13, 4'd4);
        wait_hs(0);
        repeat (3) tick();
        do_reset();
        tick();
        set_req(0, 32'd21, 32'd2, 4'd5);
        tick();
        fu_force = 1'b1;
        tick();
        fu_force = 1'b0;
        wait_hs(0);
        chk("post_rst_grant_cycle", 64'(gnt_cyc.size() > 0 ? gnt_cyc[0] : -1), 64'(LAT));
        drain();

        // Random traffic with random CDB back-pressure and requesters that withdraw.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, $urandom, $urandom, 4'($urandom));
                end else if (!hs[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 2) != 0);
        end
        drain();
`ifdef FU_MUL_SCHED_TIMEOUT_EN
        chk("err_clear", 64'(err), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
